// File: rtl/hub_pkg.sv
// hub_pkg: shared widths and FSM state encoding for the hub-to-node bus initiator.
package hub_pkg;
   localparam int HUB_ADDR_W  = 2;
   localparam int HUB_DATA_W  = 2;
   localparam int HUB_FRAME_W = 4;
   typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, FAIL} hub_state_t;
endpackage

// File: rtl/hub_node_master_if.sv
// hub_node_master_if: request/response handshake and physical bus lines of the hub initiator.
interface hub_node_master_if;
   import hub_pkg::*;
   logic                   req_valid;
   logic                   req_ready;
   logic [HUB_ADDR_W-1:0]  req_addr;
   logic [HUB_DATA_W-1:0]  req_data;
   logic [HUB_FRAME_W-1:0] bus_out;
   logic [HUB_FRAME_W-1:0] bus_in;
   logic                   rsp_valid;
   logic [HUB_ADDR_W-1:0]  rsp_addr;
   logic [HUB_DATA_W-1:0]  rsp_data;
   logic                   timeout;
   logic                   busy;
   modport master (
      input  req_valid, req_addr, req_data, bus_in,
      output req_ready, bus_out, rsp_valid, rsp_addr, rsp_data, timeout, busy
   );
   modport slave (
      output req_valid, req_addr, req_data, bus_in,
      input  req_ready, bus_out, rsp_valid, rsp_addr, rsp_data, timeout, busy
   );
endinterface

// File: rtl/hub_tick_gen.sv
// hub_tick_gen: free-running divider producing a one-cycle slow-tick pulse every TICK_DIV clocks.
module hub_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clock50,
   input  logic rst_n,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(TICK_DIV - 1);
   always_ff @(posedge clock50 or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hub_node_master.sv
// hub_node_master: sends {addr,data} frames to a node and waits for its answer or a timeout.
// Optional HUB_RETRY_EN: resend the frame once before reporting a timeout.
module hub_node_master
   import hub_pkg::*;
#(
   parameter int TICK_DIV      = 4,
   parameter int HOLD_TICKS    = 2,
   parameter int TIMEOUT_TICKS = 8
) (
   input logic             clock50,
   input logic             rst_n,
   hub_node_master_if.master bus
);
   localparam int CW = $clog2((HOLD_TICKS > TIMEOUT_TICKS ? HOLD_TICKS : TIMEOUT_TICKS) + 1);
   hub_state_t             state;
   logic                   tick;
   logic [HUB_FRAME_W-1:0] sync1, sync2;
   logic [HUB_ADDR_W-1:0]  addr_q;
   logic [HUB_DATA_W-1:0]  cap_q;
   logic [CW-1:0]          tcnt;
   logic                   match;
`ifdef HUB_RETRY_EN
   logic [HUB_DATA_W-1:0]  data_q;
   logic                   retry;
`endif
   hub_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clock50(clock50), .rst_n(rst_n), .tick(tick));
   assign match = sync2[HUB_FRAME_W-1 -: HUB_ADDR_W] == addr_q && sync2[HUB_DATA_W-1:0] != '0;
   always_ff @(posedge clock50 or negedge rst_n)
      if (!rst_n) {sync2, sync1} <= '0;
      else {sync2, sync1} <= {sync1, bus.bus_in};
   always_ff @(posedge clock50 or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         addr_q        <= '0;
         cap_q         <= '0;
         tcnt          <= '0;
         bus.bus_out   <= '0;
         bus.req_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_addr  <= '0;
         bus.rsp_data  <= '0;
         bus.timeout   <= 1'b0;
`ifdef HUB_RETRY_EN
         data_q        <= '0;
         retry         <= 1'b0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.timeout   <= 1'b0;
         case (state)
            IDLE:
               if (bus.req_valid && bus.req_ready) begin
                  state         <= SEND;
                  addr_q        <= bus.req_addr;
                  tcnt          <= '0;
                  bus.bus_out   <= {bus.req_addr, bus.req_data};
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
`ifdef HUB_RETRY_EN
                  data_q        <= bus.req_data;
`endif
               end else bus.req_ready <= 1'b1;
            SEND:
               if (tick && tcnt == CW'(HOLD_TICKS - 1)) begin
                  state       <= WAIT;
                  tcnt        <= '0;
                  bus.bus_out <= '0;
               end else if (tick) tcnt <= tcnt + 1'b1;
            WAIT:
               // a match on the final tick still wins over the expiry
               if (match) begin
                  state <= DONE;
                  cap_q <= sync2[HUB_DATA_W-1:0];
               end else if (tick && tcnt == CW'(TIMEOUT_TICKS - 1)) begin
`ifdef HUB_RETRY_EN
                  if (!retry) begin
                     retry       <= 1'b1;
                     state       <= SEND;
                     tcnt        <= '0;
                     bus.bus_out <= {addr_q, data_q};
                  end else state <= FAIL;
`else
                  state <= FAIL;
`endif
               end else if (tick) tcnt <= tcnt + 1'b1;
            DONE: begin
               state         <= IDLE;
               bus.rsp_valid <= 1'b1;
               bus.rsp_addr  <= addr_q;
               bus.rsp_data  <= cap_q;
               bus.busy      <= 1'b0;
`ifdef HUB_RETRY_EN
               retry         <= 1'b0;
`endif
            end
            FAIL: begin
               state       <= IDLE;
               bus.timeout <= 1'b1;
               bus.busy    <= 1'b0;
`ifdef HUB_RETRY_EN
               retry       <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_hub_node_master.sv
// tb_hub_node_master: directed transactions with hand-computed cycle positions relative to reset release.
module tb_hub_node_master;
   localparam int N = 100;
`ifdef HUB_RETRY_EN
   localparam int LAST = 79;
   localparam logic [3:0] RESEND = 4'b1001;
`else
   localparam int LAST = 39;
   localparam logic [3:0] RESEND = 4'b0000;
`endif
   localparam int TO = LAST + 2;
   logic clock50 = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [3:0] bo_t [N];
   logic [1:0] ra_t [N];
   logic [1:0] rd_t [N];
   logic       rv_t [N];
   logic       to_t [N];
   logic       rr_t [N];
   logic       by_t [N];
   hub_node_master_if bus ();
   hub_node_master #(.TICK_DIV(4), .HOLD_TICKS(2), .TIMEOUT_TICKS(8)) dut (
      .clock50(clock50),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clock50 = ~clock50;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clock50);
      #1;
   endtask
   function automatic logic [15:0] npulse(input bit rsp);
      int n = 0;
      for (int k = 0; k < N; k++) n += int'(rsp ? rv_t[k] : to_t[k]);
      return 16'(n);
   endfunction
   function automatic logic [15:0] outs();
      return {4'h0, bus.bus_out, bus.rsp_addr, bus.rsp_data, bus.req_ready, bus.busy, bus.rsp_valid, bus.timeout};
   endfunction
   // cycle 0 is the cycle right after release; the tick divider then fires in cycles 3, 7, 11, ...
   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr = 2'd0;
      bus.req_data = 2'd0;
      bus.bus_in = 4'h0;
      step();
      step();
      check("reset_outs", outs(), 16'h0008);
      rst_n = 1'b1;
   endtask
   task automatic scen(input logic [1:0] a, input logic [1:0] d, input logic [3:0] bv, input int bf, input int bt);
      do_reset();
      bus.req_addr = a;
      bus.req_data = d;
      for (int k = 0; k < N; k++) begin
         bus.req_valid = (k == 0);
         bus.bus_in = (k >= bf && k < bt) ? bv : 4'h0;
         bo_t[k] = bus.bus_out;
         ra_t[k] = bus.rsp_addr;
         rd_t[k] = bus.rsp_data;
         rv_t[k] = bus.rsp_valid;
         to_t[k] = bus.timeout;
         rr_t[k] = bus.req_ready;
         by_t[k] = bus.busy;
         step();
      end
   endtask
   task automatic check_normal(input string p);
      check({p, "_bo0"}, bo_t[0], 4'h0);
      check({p, "_rdy0"}, rr_t[0], 1'b1);
      check({p, "_bo1"}, bo_t[1], 4'b1001);
      check({p, "_busy1"}, by_t[1], 1'b1);
      check({p, "_bo7"}, bo_t[7], 4'b1001);
      check({p, "_bo8"}, bo_t[8], 4'h0);
      check({p, "_rv13"}, rv_t[13], 1'b0);
      check({p, "_rv14"}, rv_t[14], 1'b1);
      check({p, "_ra14"}, ra_t[14], 2'd2);
      check({p, "_rd14"}, rd_t[14], 2'd3);
      check({p, "_rdy14"}, rr_t[14], 1'b0);
      check({p, "_rdy15"}, rr_t[15], 1'b1);
      check({p, "_busy13"}, by_t[13], 1'b1);
      check({p, "_busy15"}, by_t[15], 1'b0);
      check({p, "_rhold"}, {ra_t[30], rd_t[30]}, 4'b1011);
      check({p, "_nrsp"}, npulse(1), 16'd1);
      check({p, "_nto"}, npulse(0), 16'd0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      scen(2'd2, 2'd1, 4'b1011, 10, 14);
      check_normal("norm");
      scen(2'd2, 2'd1, 4'h0, 0, 0);
      check("nr_to_pre", to_t[TO-1], 1'b0);
      check("nr_to", to_t[TO], 1'b1);
      check("nr_to_post", to_t[TO+1], 1'b0);
      check("nr_rdy_pulse", rr_t[TO], 1'b0);
      check("nr_rdy_after", rr_t[TO+1], 1'b1);
      check("nr_nto", npulse(0), 16'd1);
      check("nr_nrsp", npulse(1), 16'd0);
      check("nr_bo40", bo_t[40], RESEND);
      check("nr_bo47", bo_t[47], RESEND);
      check("nr_bo48", bo_t[48], 4'h0);
      scen(2'd2, 2'd1, 4'b0111, 10, 20);
      check("wa_nrsp", npulse(1), 16'd0);
      check("wa_to", to_t[TO], 1'b1);
      check("wa_nto", npulse(0), 16'd1);
      scen(2'd2, 2'd1, 4'b1011, LAST - 2, LAST + 3);
      check("col_rv", rv_t[TO], 1'b1);
      check("col_rsp", {ra_t[TO], rd_t[TO]}, 4'b1011);
      check("col_nto", npulse(0), 16'd0);
      check("col_rdy", rr_t[TO+1], 1'b1);
      scen(2'd2, 2'd1, 4'b1011, LAST - 1, LAST + 3);
      check("late_to", to_t[TO], 1'b1);
      check("late_nrsp", npulse(1), 16'd0);
      do_reset();
      bus.req_addr = 2'd2;
      bus.req_data = 2'd1;
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      check("mid_bo1", bus.bus_out, 4'b1001);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("mid_async", {bus.bus_out, bus.req_ready, bus.busy}, 6'b000010);
      step();
      check("mid_nopulse", {bus.rsp_valid, bus.timeout}, 2'b00);
      scen(2'd2, 2'd1, 4'b1011, 10, 14);
      check_normal("post");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
